frfb_burst_sched: RTL



---
 rtl/frfb_burst_sched.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/frfb_burst_sched.sv
// -----------------------------------------------------------------------------
// frfb_burst_sched
//
// Moves whole bursts of pixel data for the remote framebuffer.
// - Write bursts go from the LCD input FIFO into DDR.
// - Read bursts go from DDR into the LVDS output FIFO.
// - Frame buffers (NBUF = 2 or 3) rotate on the input and output vsync rising
//   edges, so the input and output frame rates can differ without tearing.
//   With three buffers, an input frame that is cut short is discarded.
//
// Parameters
//   ADDR_W        DDR command address width, in burst units
//   BURST_WORDS   32-bit words per burst (power of two, 2..64)
//   FRAME_BURSTS  bursts per frame; BIDX_W = clog2(FRAME_BURSTS), ADDR_W >= BIDX_W+2
//   NBUF          number of frame buffers, 2 or 3
//
// Optional feature
//   FRFB_RR_ARB_EN  When defined, read/write ties alternate, starting with read.
//                   When undefined, read always wins a tie.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   init_done                   DDR initialisation complete
//   in_vsync / out_vsync        frame-active levels; a rising edge starts a frame
//   in_burst_rdy                input FIFO holds a full burst
//   out_burst_rdy               output FIFO has room for a full burst
//   cmd_valid/cmd_ready         command handshake
//   cmd_r_wn                    1 = read burst, 0 = write burst
//   cmd_addr                    {zero pad, buffer[1:0], burst index}
//   dat_en                      one strobe per data word of the accepted burst
//   in_pop / out_push           FIFO strobes, combinational from dat_en
//   wr_buf / rd_buf             current write and read buffer
//   frame_drop                  one-cycle pulse when an input frame is discarded
//
// Command handshake: cmd_valid rises the cycle after a request is selected.
// While cmd_valid is high, cmd_r_wn and cmd_addr hold steady. A command
// transfers on the first clock edge where cmd_valid & cmd_ready are both high,
// and cmd_valid drops on the next cycle.
// -----------------------------------------------------------------------------
module frfb_burst_sched #(
  parameter int ADDR_W       = 15,
  parameter int BURST_WORDS  = 8,
  parameter int FRAME_BURSTS = 1280,
  parameter int NBUF         = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_done,
  input  logic              in_vsync,
  input  logic              out_vsync,
  input  logic              in_burst_rdy,
  input  logic              out_burst_rdy,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_r_wn,
  output logic [ADDR_W-1:0] cmd_addr,
  input  logic              dat_en,
  output logic              in_pop,
  output logic              out_push,
  output logic [1:0]        wr_buf,
  output logic [1:0]        rd_buf,
  output logic              frame_drop
);

  localparam int BIDX_W = $clog2(FRAME_BURSTS);
  // Burst indices must be able to hold FRAME_BURSTS itself ("frame complete").
  localparam int IDX_W  = $clog2(FRAME_BURSTS + 1);
  localparam int CNT_W  = $clog2(BURST_WORDS);

  localparam logic [IDX_W-1:0] FRAME_END = IDX_W'(FRAME_BURSTS);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BURST_WORDS - 1);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_CMD,
    S_DATA
  } state_t;

  state_t             state_q, state_d;
  logic               in_vsync_q, out_vsync_q;
  logic               pend_in_q, pend_out_q;
  logic [1:0]         last_done_q;
  logic [IDX_W-1:0]   wr_idx_q, rd_idx_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               in_rise, out_rise, in_edge, out_edge;
  logic               wr_req, rd_req, grant_rd, grant_wr;
  logic               apply_edges, take_rd, take_wr, burst_done;
  logic               wr_complete, drop;
  logic [1:0]         new_last, new_wr, new_rd;

`ifdef FRFB_RR_ARB_EN
  // 1 when the most recent grant went to the read side.
  logic               last_rd_q;
`endif

  // Edges seen this cycle count as pending, so a pending edge never waits an
  // extra cycle when the FSM is already idle.
  assign in_rise  = in_vsync  & ~in_vsync_q;
  assign out_rise = out_vsync & ~out_vsync_q;
  assign in_edge  = pend_in_q  | in_rise;
  assign out_edge = pend_out_q | out_rise;

  assign wr_req = in_vsync  & in_burst_rdy  & (wr_idx_q < FRAME_END);
  assign rd_req = out_vsync & out_burst_rdy & (rd_idx_q < FRAME_END);

`ifdef FRFB_RR_ARB_EN
  assign grant_rd = rd_req & (~wr_req | ~last_rd_q);
`else
  assign grant_rd = rd_req;
`endif
  assign grant_wr = wr_req & ~grant_rd;

  // Buffer rotation on an input edge. The read side then picks up whatever
  // last_done will be after that rotation.
  always_comb begin
    wr_complete = (wr_idx_q == FRAME_END);
    drop        = 1'b0;
    new_last    = wr_buf;
    new_wr      = wr_buf;
    if (NBUF == 3) begin
      if (!wr_complete) begin
        new_last = last_done_q;
        drop     = 1'b1;
      end
      // With rd_buf == new_last (a drop right after an output edge), the
      // current write buffer is already free of both, so keep it.
      if (rd_buf != new_last) begin
        new_wr = 2'd3 - rd_buf - new_last;
      end
    end else begin
      new_wr = {1'b0, ~new_last[0]};
    end
    new_rd = in_edge ? new_last : last_done_q;
  end

  // FSM next state and control strobes.
  always_comb begin
    state_d     = state_q;
    apply_edges = 1'b0;
    take_rd     = 1'b0;
    take_wr     = 1'b0;
    burst_done  = 1'b0;
    case (state_q)
      S_INIT: begin
        if (init_done) state_d = S_IDLE;
      end
      S_IDLE: begin
        // Frame rotation consumes the idle cycle, so a new burst always sees
        // the rotated buffers and cleared indices.
        if (in_edge || out_edge) begin
          apply_edges = 1'b1;
        end else if (grant_rd) begin
          take_rd = 1'b1;
          state_d = S_CMD;
        end else if (grant_wr) begin
          take_wr = 1'b1;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (cmd_ready) state_d = S_DATA;
      end
      S_DATA: begin
        if (dat_en && (cnt_q == LAST_WORD)) begin
          burst_done = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      in_vsync_q  <= 1'b0;
      out_vsync_q <= 1'b0;
      pend_in_q   <= 1'b0;
      pend_out_q  <= 1'b0;
      last_done_q <= 2'd0;
      wr_buf      <= 2'd1;
      rd_buf      <= 2'd0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      cnt_q       <= '0;
      cmd_valid   <= 1'b0;
      cmd_r_wn    <= 1'b1;
      cmd_addr    <= '0;
      frame_drop  <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_vsync_q  <= in_vsync;
      out_vsync_q <= out_vsync;
      cmd_valid   <= (state_d == S_CMD);
      frame_drop  <= 1'b0;

      if (apply_edges) begin
        pend_in_q  <= 1'b0;
        pend_out_q <= 1'b0;
        if (in_edge) begin
          last_done_q <= new_last;
          wr_buf      <= new_wr;
          wr_idx_q    <= '0;
          frame_drop  <= drop;
        end
        if (out_edge) begin
          rd_buf   <= new_rd;
          rd_idx_q <= '0;
        end
      end else begin
        pend_in_q  <= pend_in_q  | in_rise;
        pend_out_q <= pend_out_q | out_rise;
      end

      if (take_rd) begin
        cmd_r_wn <= 1'b1;
        cmd_addr <= ADDR_W'({rd_buf, rd_idx_q[BIDX_W-1:0]});
      end else if (take_wr) begin
        cmd_r_wn <= 1'b0;
        cmd_addr <= ADDR_W'({wr_buf, wr_idx_q[BIDX_W-1:0]});
      end

      // BURST_WORDS is a power of two, so the counter wraps to zero on the
      // last strobe by itself.
      if (state_q == S_DATA) begin
        if (dat_en) cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        cnt_q <= '0;
      end

      if (burst_done) begin
        if (cmd_r_wn) rd_idx_q <= rd_idx_q + IDX_W'(1);
        else          wr_idx_q <= wr_idx_q + IDX_W'(1);
      end
    end
  end

`ifdef FRFB_RR_ARB_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_rd_q <= 1'b0;
    end else if (take_rd) begin
      last_rd_q <= 1'b1;
    end else if (take_wr) begin
      last_rd_q <= 1'b0;
    end
  end
`endif

  // dat_en is only meaningful while a burst is in its data phase.
  assign in_pop   = dat_en & (state_q == S_DATA) & ~cmd_r_wn;
  assign out_push = dat_en & (state_q == S_DATA) &  cmd_r_wn;

endmodule
